// File: rtl/btb_pkg.sv
// Shared types for the BTB update path: drain FSM states, the queued
// update record and the mispredict rule used at resolution.
package btb_pkg;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_WRITE = 1'b1
   } drain_state_e;

   // idx holds the zero-extended BTB index so it can drive BTB_Addr directly
   typedef struct packed {
      logic [31:0] idx;
      logic [31:0] target;
   } btb_upd_t;

   function automatic logic is_mispredict(
      input logic        res_taken,
      input logic [31:0] res_target,
      input logic        pred_taken,
      input logic [31:0] pred_target
   );
      return (res_taken != pred_taken) || (res_taken && (res_target != pred_target));
   endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Pending BTB update queue: FIFO order with in-place coalescing of updates
// whose index already sits in the queue.
module btb_upd_fifo
   import btb_pkg::*;
#(
   parameter int unsigned QDEPTH = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    upd_valid,
   input  btb_upd_t                upd,
   input  logic                    pop,
   output btb_upd_t                head,
   output logic                    head_hit,
   output logic [$clog2(QDEPTH):0] count
);

   localparam int unsigned PW = $clog2(QDEPTH);
   localparam int unsigned CW = PW + 1;

   btb_upd_t          mem [QDEPTH];
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;
   logic              hit;
   logic [PW-1:0]     hit_slot;
   logic              append;

   // The head leaving this cycle is excluded, so a match on it falls through to an append.
   always_comb begin
      hit      = 1'b0;
      hit_slot = '0;
      for (int unsigned k = 0; k < QDEPTH; k++) begin
         if ((CW'(k) < count) && !(pop && (k == 0)) &&
             (mem[rd_ptr + PW'(k)].idx == upd.idx)) begin
            hit      = upd_valid;
            hit_slot = rd_ptr + PW'(k);
         end
      end
   end

   assign append   = upd_valid && !hit;
   assign head     = mem[rd_ptr];
   assign head_hit = hit && (hit_slot == rd_ptr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int unsigned i = 0; i < QDEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (hit) begin
            mem[hit_slot] <= upd;
         end else if (append) begin
            mem[wr_ptr] <= upd;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(append) - CW'(pop);
      end
   end

endmodule

// File: rtl/btb_update_ctrl.sv
// Branch resolution front end: detects mispredicts, issues fetch redirects
// and drains queued BTB updates through a two-state write FSM.
module btb_update_ctrl
   import btb_pkg::*;
#(
   parameter int unsigned QDEPTH = 4,
   parameter int unsigned IDX_W  = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    Resolve_Valid,
   output logic                    Resolve_Ready,
   input  logic [31:0]             Resolve_PC,
   input  logic                    Resolve_Taken,
   input  logic [31:0]             Resolve_Target,
   input  logic                    Pred_Taken,
   input  logic [31:0]             Pred_Target,
   input  logic                    BTB_Wr_Block,
   output logic                    BTB_Wr_En,
   output logic [31:0]             BTB_Addr,
   output logic [31:0]             BTB_Entry,
   output logic                    Redirect_Valid,
   output logic [31:0]             Redirect_PC,
   output logic [$clog2(QDEPTH):0] Queue_Count
);

   localparam int unsigned CW = $clog2(QDEPTH) + 1;

   drain_state_e state;
   logic         accept;
   logic         mispredict;
   logic         upd_valid;
   btb_upd_t     upd;
   btb_upd_t     head;
   logic         head_hit;
   logic         pop;

   assign Resolve_Ready = (Queue_Count < CW'(QDEPTH));
   assign accept        = Resolve_Valid && Resolve_Ready;
   assign mispredict    = is_mispredict(Resolve_Taken, Resolve_Target, Pred_Taken, Pred_Target);

   assign upd_valid = accept &&
                      ((Resolve_Taken && (Resolve_Target != Pred_Target)) ||
                       (!Resolve_Taken && (Pred_Target != '0)));
   assign upd.idx    = 32'(Resolve_PC[IDX_W-1:0]);
   assign upd.target = Resolve_Taken ? Resolve_Target : '0;

   assign pop = (state == ST_WRITE);

   btb_upd_fifo #(
      .QDEPTH (QDEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .upd_valid (upd_valid),
      .upd       (upd),
      .pop       (pop),
      .head      (head),
      .head_hit  (head_hit),
      .count     (Queue_Count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         BTB_Wr_En      <= 1'b0;
         BTB_Addr       <= '0;
         BTB_Entry      <= '0;
         Redirect_Valid <= 1'b0;
         Redirect_PC    <= '0;
      end else begin
         Redirect_Valid <= accept && mispredict;
         if (accept && mispredict) begin
            Redirect_PC <= Resolve_Taken ? Resolve_Target : Resolve_PC + 32'd4;
         end
         case (state)
            ST_IDLE: begin
               BTB_Wr_En <= 1'b0;
               if ((Queue_Count != '0) && !BTB_Wr_Block) begin
                  state     <= ST_WRITE;
                  BTB_Wr_En <= 1'b1;
                  BTB_Addr  <= head.idx;
                  // A same-cycle coalesce into the head must reach the BTB, not the stale data.
                  BTB_Entry <= head_hit ? upd.target : head.target;
               end
            end
            ST_WRITE: begin
               state     <= ST_IDLE;
               BTB_Wr_En <= 1'b0;
            end
            default: begin
               state     <= ST_IDLE;
               BTB_Wr_En <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/btb_update_ctrl.md
BTB_UPDATE_CTRL -- requirements
Module: btb_update_ctrl

Interface
REQ-001 SHALL have parameter QDEPTH, default 4: depth of the pending-update queue (power of two, 2..8).
REQ-002 SHALL have parameter IDX_W, default 4: BTB index width; index = PC[IDX_W-1:0].
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Resolve_Valid  input  1  execute presents a resolved branch.
REQ-006 Resolve_Ready  output  1  resolution accepted this cycle when Valid&Ready.
REQ-007 Resolve_PC  input  32  branch PC.
REQ-008 Resolve_Taken  input  1  actual direction.
REQ-009 Resolve_Target  input  32  actual taken target.
REQ-010 Pred_Taken  input  1  direction predicted at fetch.
REQ-011 Pred_Target  input  32  BTB target used at fetch.
REQ-012 BTB_Wr_Block  input  1  fetch owns the BTB this cycle; no write may issue.
REQ-013 BTB_Wr_En  output  1  one-cycle write strobe to the BTB.
REQ-014 BTB_Addr  output  32  write address; bits above IDX_W driven 0.
REQ-015 BTB_Entry  output  32  write data (new target).
REQ-016 Redirect_Valid  output  1  one-cycle fetch redirect on mispredict.
REQ-017 Redirect_PC  output  32  corrected fetch PC.
REQ-018 Queue_Count  output  $clog2(QDEPTH)+1  pending updates.

Function
REQ-019 Mispredict SHALL be defined as (Resolve_Taken != Pred_Taken) or (Resolve_Taken and Resolve_Target != Pred_Target).
REQ-020 Accepted mispredict SHALL assert Redirect_Valid exactly one cycle after acceptance, with Redirect_PC = Resolve_Target if taken, else Resolve_PC+4 (mod 2^32).
REQ-021 Accepted resolution SHALL generate an update when taken and Resolve_Target != Pred_Target (entry = Resolve_Target), or when not taken and Pred_Target != 0 (entry = 0, clear); otherwise no update.
REQ-022 An update whose index matches a queued entry not being written this cycle SHALL overwrite that entry's data in place (coalesce); Queue_Count is unchanged.
REQ-023 A non-coalescing update SHALL be appended at the tail; order is FIFO.
REQ-024 Resolve_Ready SHALL be 1 iff Queue_Count < QDEPTH; no same-cycle bypass when full.
REQ-025 Drain FSM states: IDLE, WRITE. IDLE->WRITE when queue non-empty and BTB_Wr_Block=0; WRITE->IDLE unconditionally after one cycle, popping the head.
REQ-026 In WRITE, BTB_Wr_En=1 and BTB_Addr/BTB_Entry SHALL present the head; outside WRITE, BTB_Wr_En=0 and Addr/Entry SHALL hold their last values.
REQ-027 Max drain rate SHALL be one write per two cycles.
REQ-028 Simultaneous pop and append SHALL leave Queue_Count unchanged; a coalesce into the popping head SHALL instead append.
REQ-029 Read/write pointers SHALL wrap modulo QDEPTH.

Reset
REQ-030 On rst_n=0, immediately: queue emptied, Queue_Count=0, FSM=IDLE, BTB_Wr_En=0, Redirect_Valid=0, BTB_Addr=0, BTB_Entry=0, Redirect_PC=0; Resolve_Ready=1 after release.
REQ-031 Reset during WRITE SHALL abort the write; pending updates are discarded.

Structure
REQ-032 FSM state encoding and the queue-entry record (index, target) SHALL live in a shared btb_pkg package.
REQ-033 Queue storage SHALL be a sub-module btb_upd_fifo with coalesce lookup port; mispredict detect and FSM in the top.

Verification
REQ-034 Taken, PC=0x104, Pred_Taken=0, target 0x200 -> next cycle Redirect 0x200; write Addr=0x4, Entry=0x200.
REQ-035 Not taken, PC=0x108, Pred_Taken=1, Pred_Target=0x300 -> Redirect 0x10C; write Addr=0x8, Entry=0.
REQ-036 Two updates to PC 0x10 then 0x20 (same index 0), BTB_Wr_Block=1 -> Queue_Count=1, single write Entry=second target.
REQ-037 Five distinct-index updates, Wr_Block=1 -> Ready=0 after fourth; fifth held until a write drains.
REQ-038 Correct prediction (taken, targets equal) -> no Redirect, no write, Queue_Count=0.
REQ-039 rst_n low during WRITE with 3 queued -> Wr_En=0 immediately, Queue_Count=0, no writes after release.
